// File: rtl/pe_array_sequencer.sv
// Command sequencer for the processing-element array: runs a Cannon-style
// schedule of multiply, shift-A, shift-B for a programmed number of steps.
module pe_array_sequencer #(
    parameter int NUM_IMAGES = 2,
    parameter int IDX_W      = 1,
    parameter int STEP_W     = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [IDX_W-1:0]  img_a,
    input  logic [IDX_W-1:0]  img_b,
    input  logic [1:0]        dir_a,
    input  logic [1:0]        dir_b,
    input  logic              pe_ready,
    input  logic              pe_error,
    output logic              shift_left,
    output logic              shift_right,
    output logic              shift_up,
    output logic              shift_down,
    output logic [IDX_W-1:0]  image_shifting,
    output logic              start_multiply,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [STEP_W-1:0] step_count
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        ISSUE_MUL,
        WAIT_MUL,
        ISSUE_SA,
        WAIT_SA,
        ISSUE_SB,
        WAIT_SB,
        FINISH,
        ERR
    } state_t;

    state_t             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [IDX_W-1:0]   ishift_q, ishift_d;

    logic [STEP_W-1:0]  num_q;
    logic [IDX_W-1:0]   img_a_q, img_b_q;
    logic [1:0]         dir_a_q, dir_b_q;

    logic               cfg_load;
    logic               in_wait;
    logic               busy_st;
    logic               ready_ok;
    logic               timed_out;
    logic               last_step;

    // An index beyond the images held by a PE is meaningless; pin it to the last one.
    function automatic logic [IDX_W-1:0] clamp_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) > NUM_IMAGES - 1) begin
            return IDX_W'(NUM_IMAGES - 1);
        end
        return idx;
    endfunction

    assign cfg_load  = (state_q == IDLE) && start;
    assign in_wait   = (state_q == WAIT_MUL) || (state_q == WAIT_SA) || (state_q == WAIT_SB);
    assign busy_st   = (state_q != IDLE) && (state_q != ERR);
    // First wait cycle is blanked: PEs drop ready one cycle after the command.
    assign ready_ok  = in_wait && (wcnt_q != '0) && pe_ready;
    assign timed_out = in_wait && (wcnt_q == WCNT_LAST);
    assign last_step = ((step_q + STEP_W'(1)) == num_q);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            wcnt_q   <= '0;
            ishift_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            wcnt_q   <= wcnt_d;
            ishift_q <= ishift_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (cfg_load) begin
            num_q   <= num_steps;
            img_a_q <= clamp_idx(img_a);
            img_b_q <= clamp_idx(img_b);
            dir_a_q <= dir_a;
            dir_b_q <= dir_b;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_steps == '0) ? FINISH : ISSUE_MUL;
                end
            end
            ISSUE_MUL: state_d = WAIT_MUL;
            ISSUE_SA:  state_d = WAIT_SA;
            ISSUE_SB:  state_d = WAIT_SB;
            WAIT_MUL: begin
                if (ready_ok) begin
                    state_d = last_step ? FINISH : ISSUE_SA;
                end else if (timed_out) begin
                    state_d = ERR;
                end
            end
            WAIT_SA: begin
                if (ready_ok) begin
                    state_d = ISSUE_SB;
                end else if (timed_out) begin
                    state_d = ERR;
                end
            end
            WAIT_SB: begin
                if (ready_ok) begin
                    state_d = ISSUE_MUL;
                end else if (timed_out) begin
                    state_d = ERR;
                end
            end
            FINISH:  state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        // A PE fault overrides any ready-driven advance or completion.
        if (busy_st && pe_error) begin
            state_d = ERR;
        end
    end

    always_comb begin
        step_d   = step_q;
        wcnt_d   = '0;
        ishift_d = ishift_q;
        if (cfg_load) begin
            step_d = '0;
        end else if ((state_q == WAIT_MUL) && ready_ok && !pe_error) begin
            step_d = step_q + STEP_W'(1);
        end
        if (in_wait) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
        end
        if (state_d == ISSUE_SA) begin
            ishift_d = img_a_q;
        end else if (state_d == ISSUE_SB) begin
            ishift_d = img_b_q;
        end
    end

    logic       is_shift;
    logic [1:0] sel_dir;

    always_comb begin
        is_shift       = (state_q == ISSUE_SA) || (state_q == ISSUE_SB);
        sel_dir        = (state_q == ISSUE_SA) ? dir_a_q : dir_b_q;
        shift_left     = is_shift && (sel_dir == 2'b00);
        shift_right    = is_shift && (sel_dir == 2'b01);
        shift_up       = is_shift && (sel_dir == 2'b10);
        shift_down     = is_shift && (sel_dir == 2'b11);
        start_multiply = (state_q == ISSUE_MUL);
        busy           = busy_st;
        done           = (state_q == FINISH);
        error          = (state_q == ERR);
        step_count     = step_q;
        image_shifting = ishift_q;
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer with a simple PE-ready responder.
module tb_pe_array_sequencer;

    localparam int NUM_IMAGES = 2;
    localparam int IDX_W      = 1;
    localparam int STEP_W     = 8;
    localparam int TIMEOUT    = 10;

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [STEP_W-1:0] num_steps = '0;
    logic [IDX_W-1:0]  img_a = '0, img_b = '0;
    logic [1:0]        dir_a = '0, dir_b = '0;
    logic              pe_ready;
    logic              pe_error = 1'b0;
    logic              shift_left, shift_right, shift_up, shift_down;
    logic [IDX_W-1:0]  image_shifting;
    logic              start_multiply, busy, done, error;
    logic [STEP_W-1:0] step_count;

    pe_array_sequencer #(
        .NUM_IMAGES(NUM_IMAGES), .IDX_W(IDX_W), .STEP_W(STEP_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .reset(reset), .start(start), .num_steps(num_steps),
        .img_a(img_a), .img_b(img_b), .dir_a(dir_a), .dir_b(dir_b),
        .pe_ready(pe_ready), .pe_error(pe_error),
        .shift_left(shift_left), .shift_right(shift_right),
        .shift_up(shift_up), .shift_down(shift_down),
        .image_shifting(image_shifting), .start_multiply(start_multiply),
        .busy(busy), .done(done), .error(error), .step_count(step_count)
    );

    always #5 CLK = ~CLK;

    // PE model: ready drops the cycle after any command, back high the cycle after.
    logic       ready_en = 1'b1;
    logic [1:0] since_q = 2'd3;
    logic       any_pulse;
    assign any_pulse = start_multiply | shift_left | shift_right | shift_up | shift_down;
    assign pe_ready  = ready_en && (since_q != 2'd0);

    always @(posedge CLK) begin
        if (reset) since_q <= 2'd3;
        else if (any_pulse) since_q <= 2'd0;
        else if (since_q != 2'd3) since_q <= since_q + 2'd1;
    end

    // Event monitor: codes 0=MUL 1=L 2=R 3=U 4=D
    int cyc = 0, n_mul = 0, n_l = 0, n_r = 0, n_u = 0, n_d = 0, n_done = 0, multi = 0;
    int idx_l = -1, idx_r = -1, idx_u = -1, idx_d = -1;
    int ev_code[$];
    int ev_cyc[$];
    int np;

    always @(negedge CLK) begin
        cyc++;
        np = int'(start_multiply) + int'(shift_left) + int'(shift_right)
           + int'(shift_up) + int'(shift_down);
        if (np > 1) multi++;
        if (start_multiply) begin n_mul++; ev_code.push_back(0); ev_cyc.push_back(cyc); end
        if (shift_left)  begin n_l++; idx_l = int'(image_shifting); ev_code.push_back(1); ev_cyc.push_back(cyc); end
        if (shift_right) begin n_r++; idx_r = int'(image_shifting); ev_code.push_back(2); ev_cyc.push_back(cyc); end
        if (shift_up)    begin n_u++; idx_u = int'(image_shifting); ev_code.push_back(3); ev_cyc.push_back(cyc); end
        if (shift_down)  begin n_d++; idx_d = int'(image_shifting); ev_code.push_back(4); ev_cyc.push_back(cyc); end
        if (done) n_done++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clear_mon();
        n_mul = 0; n_l = 0; n_r = 0; n_u = 0; n_d = 0; n_done = 0;
        idx_l = -1; idx_r = -1; idx_u = -1; idx_d = -1;
        ev_code.delete();
        ev_cyc.delete();
    endtask

    task automatic do_start(input int n, input int ia, input int ib, input int da, input int db);
        @(posedge CLK); #1;
        num_steps = STEP_W'(n);
        img_a = IDX_W'(ia); img_b = IDX_W'(ib);
        dir_a = 2'(da); dir_b = 2'(db);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK);
            if (done || error) begin seen = 1'b1; break; end
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_pulse(input string tag, input int code, input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK);
            if ((code == 1 && shift_left) || (code == 3 && shift_up)) begin seen = 1'b1; break; end
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({shift_left, shift_right, shift_up, shift_down, start_multiply,
                    busy, done, error, step_count, image_shifting});
    endfunction

    int exp3[7] = '{0, 1, 3, 0, 1, 3, 0};
    int exp2[4] = '{0, 2, 4, 0};
    int bad;
    int nwait;

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        check_eq("reset_outs", out_vec(), 32'd0);

        // Single step
        clear_mon();
        do_start(1, 0, 0, 0, 0);
        @(negedge CLK);
        check_eq("t1_busy", 32'(busy), 32'd1);
        wait_end("t1_end_bound", 20);
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_busy_fin", 32'(busy), 32'd1);
        @(posedge CLK); #1;
        check_eq("t1_busy_after", 32'(busy), 32'd0);
        check_eq("t1_step", 32'(step_count), 32'd1);
        check_eq("t1_mul", 32'(n_mul), 32'd1);
        check_eq("t1_shifts", 32'(n_l + n_r + n_u + n_d), 32'd0);
        check_eq("t1_ndone", 32'(n_done), 32'd1);

        // Three steps: MUL L U MUL L U MUL, 3 cycles apart
        clear_mon();
        do_start(3, 0, 1, 0, 2);
        wait_end("t2_end_bound", 60);
        @(posedge CLK); #1;
        check_eq("t2_len", 32'(ev_code.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check_eq($sformatf("t2_seq%0d", i), (i < ev_code.size()) ? 32'(ev_code[i]) : 32'hFFFF, 32'(exp3[i]));
        bad = 0;
        for (int i = 1; i < ev_cyc.size(); i++)
            if (ev_cyc[i] - ev_cyc[i-1] != 3) bad++;
        check_eq("t2_spacing", 32'(bad), 32'd0);
        check_eq("t2_mul", 32'(n_mul), 32'd3);
        check_eq("t2_left", 32'(n_l), 32'd2);
        check_eq("t2_up", 32'(n_u), 32'd2);
        check_eq("t2_idx_l", 32'(idx_l), 32'd0);
        check_eq("t2_idx_u", 32'(idx_u), 32'd1);
        check_eq("t2_step", 32'(step_count), 32'd3);
        check_eq("t2_ndone", 32'(n_done), 32'd1);

        // Zero steps
        clear_mon();
        @(posedge CLK); #1;
        num_steps = '0; start = 1'b1;
        @(negedge CLK);
        check_eq("t3_done_c1", 32'(done), 32'd0);
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        check_eq("t3_done_c2", 32'(done), 32'd1);
        check_eq("t3_busy_c2", 32'(busy), 32'd1);
        @(posedge CLK); #1;
        check_eq("t3_busy_after", 32'(busy), 32'd0);
        check_eq("t3_step", 32'(step_count), 32'd0);
        check_eq("t3_pulses", 32'(n_mul + n_l + n_r + n_u + n_d), 32'd0);
        check_eq("t3_ndone", 32'(n_done), 32'd1);

        // Timeout: ready never returns after the first multiply
        clear_mon();
        ready_en = 1'b0;
        do_start(5, 0, 1, 0, 2);
        nwait = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (error) break;
            nwait++;
        end
        check_eq("t4_cycles_to_err", 32'(nwait), 32'd11);
        check_eq("t4_error", 32'(error), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd0);
        ready_en = 1'b1;
        do_start(2, 0, 1, 0, 2);
        repeat (10) @(posedge CLK);
        #1;
        check_eq("t4_mul", 32'(n_mul), 32'd1);
        check_eq("t4_shifts", 32'(n_l + n_r + n_u + n_d), 32'd0);
        check_eq("t4_sticky", 32'(error), 32'd1);
        check_eq("t4_busy_ign", 32'(busy), 32'd0);
        check_eq("t4_ndone", 32'(n_done), 32'd0);
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        @(negedge CLK);
        check_eq("t4_reset_clr", out_vec(), 32'd0);

        // pe_error during the first WAIT_SA
        clear_mon();
        do_start(3, 0, 1, 0, 2);
        wait_pulse("t5_sa_bound", 1, 20);
        @(posedge CLK); #1;
        pe_error = 1'b1;
        @(negedge CLK);
        check_eq("t5_err_pre", 32'(error), 32'd0);
        @(posedge CLK); #1;
        pe_error = 1'b0;
        @(negedge CLK);
        check_eq("t5_error", 32'(error), 32'd1);
        check_eq("t5_busy", 32'(busy), 32'd0);
        repeat (6) @(posedge CLK);
        #1;
        check_eq("t5_step", 32'(step_count), 32'd1);
        check_eq("t5_mul", 32'(n_mul), 32'd1);
        check_eq("t5_left", 32'(n_l), 32'd1);
        check_eq("t5_up", 32'(n_u), 32'd0);
        check_eq("t5_ndone", 32'(n_done), 32'd0);
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;

        // Reset during WAIT_SB, then re-arm with a stray start mid-job
        clear_mon();
        do_start(3, 0, 1, 0, 2);
        wait_pulse("t6_sb_bound", 3, 20);
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        @(negedge CLK);
        check_eq("t6_reset_outs", out_vec(), 32'd0);
        clear_mon();
        do_start(2, 1, 0, 1, 3);
        @(posedge CLK); #1;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        wait_end("t6_end_bound", 40);
        @(posedge CLK); #1;
        check_eq("t6_len", 32'(ev_code.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t6_seq%0d", i), (i < ev_code.size()) ? 32'(ev_code[i]) : 32'hFFFF, 32'(exp2[i]));
        check_eq("t6_idx_r", 32'(idx_r), 32'd1);
        check_eq("t6_idx_d", 32'(idx_d), 32'd0);
        check_eq("t6_step", 32'(step_count), 32'd2);
        check_eq("t6_ndone", 32'(n_done), 32'd1);
        check_eq("t6_error", 32'(error), 32'd0);

        check_eq("onehot_pulses", 32'(multi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
